// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache line-fill/write-back port, backed by a word-wide 1-cycle SRAM.
// Optional macro CRITICAL_WORD_FIRST_EN: line reads start at rd_addr[3:2] and wrap modulo 4.
module cache_mem_responder #(
    parameter int MEM_AW = 14
) (
    input  logic              clk_g,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [2:0]        rd_type,
    input  logic [31:0]       rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [31:0]       ret_data,
    input  logic              wr_req,
    input  logic [2:0]        wr_type,
    input  logic [31:0]       wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [127:0]      wr_data,
    output logic              wr_rdy,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              line_q, line_d;
    logic [1:0]        start_q, start_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [127:0]      wdata_q, wdata_d;
    logic              iss_q, iss_d;
    logic              last_q, last_d;
    logic [31:0]       hold_q, hold_d;

    logic              rd_line, wr_line;
    logic [2:0]        beats;
    logic [1:0]        widx;
    logic              unused_addr_bits;

    assign rd_line = (rd_type == 3'b100);
    assign wr_line = (wr_type == 3'b100);
    assign unused_addr_bits = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0], wr_addr[31:MEM_AW+2], wr_addr[1:0]};

    assign wr_rdy    = (state_q == IDLE) && !reset;
    assign rd_rdy    = (state_q == IDLE) && !wr_req && !reset;
    assign ret_valid = iss_q && !reset;
    assign ret_last  = last_q && !reset;
    // Beat data comes straight from the SRAM; the held copy keeps ret_data stable between beats.
    assign ret_data  = iss_q ? mem_rdata : hold_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        line_d    = line_q;
        start_d   = start_q;
        cnt_d     = cnt_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        iss_d     = 1'b0;
        last_d    = 1'b0;
        hold_d    = iss_q ? mem_rdata : hold_q;
        beats     = line_q ? 3'd4 : 3'd1;
        widx      = start_q + cnt_q[1:0];
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = line_q ? {addr_q[MEM_AW-1:2], widx} : addr_q;
        mem_wdata = wdata_q[32*widx +: 32];

        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    addr_d  = wr_line ? {wr_addr[MEM_AW+1:4], 2'b00} : wr_addr[MEM_AW+1:2];
                    line_d  = wr_line;
                    start_d = 2'b00;
                    wstrb_d = wr_wstrb;
                    wdata_d = wr_data;
                    cnt_d   = '0;
                    state_d = WR;
                end else if (rd_req) begin
                    addr_d  = rd_line ? {rd_addr[MEM_AW+1:4], 2'b00} : rd_addr[MEM_AW+1:2];
                    line_d  = rd_line;
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d = rd_line ? rd_addr[3:2] : 2'b00;
`else
                    start_d = 2'b00;
`endif
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                if (cnt_q != beats) begin
                    mem_en = 1'b1;
                    cnt_d  = cnt_q + 3'd1;
                    iss_d  = 1'b1;
                    last_d = (cnt_q == beats - 3'd1);
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            WR: begin
                mem_en = 1'b1;
                mem_we = line_q ? 4'hF : wstrb_q;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == beats - 3'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            mem_en = 1'b0;
            mem_we = '0;
        end
    end

    always_ff @(posedge clk_g) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            line_q  <= 1'b0;
            start_q <= '0;
            cnt_q   <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            iss_q   <= 1'b0;
            last_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            iss_q   <= iss_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed timing sequences, a vector table and
// randomized traffic against a word-array reference model. Honours CRITICAL_WORD_FIRST_EN.
module tb_cache_mem_responder;

    localparam int MEM_AW = 14;
    localparam int DEPTH  = 1 << MEM_AW;

    logic              clk_g = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [2:0]        rd_type;
    logic [31:0]       rd_addr;
    logic              rd_rdy;
    logic              ret_valid;
    logic              ret_last;
    logic [31:0]       ret_data;
    logic              wr_req;
    logic [2:0]        wr_type;
    logic [31:0]       wr_addr;
    logic [3:0]        wr_wstrb;
    logic [127:0]      wr_data;
    logic              wr_rdy;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    cache_mem_responder #(.MEM_AW(MEM_AW)) dut (
        .clk_g(clk_g), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clk_g = ~clk_g;

    // Backing SRAM attached to the DUT; the bench preloads it through the bd_* side port.
    logic [31:0] sram [DEPTH];
    logic        clr, bd_en;
    logic [MEM_AW-1:0] bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk_g) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= '0;
        end else if (bd_en) begin
            sram[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_we == 4'h0) mem_rdata <= sram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: plain word array plus the queue of beats still owed to the cache.
    logic [31:0] ref_mem [DEPTH];
    typedef struct { logic [31:0] d; logic l; } beat_t;
    beat_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] cwf_start(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
        return a[3:2];
`else
        return 2'd0;
`endif
    endfunction

    task automatic model_write(input logic [2:0] typ, input logic [31:0] a,
                               input logic [3:0] strb, input logic [127:0] d);
        int idx;
        int base;
        idx  = int'(a[MEM_AW+1:2]);
        base = int'(a[MEM_AW+1:4]) * 4;
        if (typ == 3'b100) begin
            for (int i = 0; i < 4; i++) ref_mem[base + i] = d[32*i +: 32];
        end else begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic model_read(input logic [2:0] typ, input logic [31:0] a);
        int base;
        int s;
        base = int'(a[MEM_AW+1:4]) * 4;
        s    = int'(cwf_start(a));
        if (typ == 3'b100) begin
            for (int i = 0; i < 4; i++)
                exp_q.push_back('{ref_mem[base + ((s + i) % 4)], (i == 3)});
        end else begin
            exp_q.push_back('{ref_mem[int'(a[MEM_AW+1:2])], 1'b1});
        end
    endtask

    always @(negedge clk_g) begin
        beat_t e;
        if (ret_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%08h, expected no beat", ret_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", ret_data, e.d);
                chk("beat_last", 32'(ret_last), 32'(e.l));
            end
        end else if (ret_last) begin
            chk("last_without_valid", 32'(ret_last), 32'd0);
        end
    end

    // All tasks below start and end just after a rising edge.
    task automatic preload(input int a, input logic [31:0] d);
        bd_en = 1'b1; bd_addr = MEM_AW'(a); bd_data = d;
        @(posedge clk_g); #1;
        bd_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_g);
            if (wr_rdy && exp_q.size() == 0) ok = 1;
        end
        @(posedge clk_g); #1;
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_req(input logic is_wr, input logic [2:0] typ, input logic [31:0] a,
                          input logic [3:0] strb, input logic [127:0] d,
                          input logic use_exp, input logic [31:0] exp_word);
        bit done = 0;
        if (is_wr) begin
            wr_req = 1'b1; wr_type = typ; wr_addr = a; wr_wstrb = strb; wr_data = d;
        end else begin
            rd_req = 1'b1; rd_type = typ; rd_addr = a;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_g);
            if (is_wr ? wr_rdy : rd_rdy) begin
                done = 1;
                if (is_wr) model_write(typ, a, strb, d);
                else if (use_exp) exp_q.push_back('{exp_word, 1'b1});
                else model_read(typ, a);
            end
        end
        @(posedge clk_g); #1;
        if (is_wr) wr_req = 1'b0; else rd_req = 1'b0;
        chk("req_accept_timeout", 32'(done), 32'd1);
    endtask

    // Cycle-exact line read: k counts cycles from the accept cycle T.
    task automatic line_read_capture(input string nm, input logic [31:0] a,
                                     input logic [3:0][31:0] exp);
        logic        rv [7];
        logic        rl [7];
        logic        rr [7];
        logic [31:0] rdat [7];
        wait_idle();
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = a;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_g);
            rv[k] = ret_valid; rl[k] = ret_last; rr[k] = rd_rdy; rdat[k] = ret_data;
            if (k == 0) begin
                model_read(3'b100, a);
                @(posedge clk_g); #1;
                rd_req = 1'b0;
            end
        end
        @(posedge clk_g); #1;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("%s_valid_c%0d", nm, k), 32'(rv[k]), 32'(k >= 2 && k <= 5));
            chk($sformatf("%s_last_c%0d", nm, k), 32'(rl[k]), 32'(k == 5));
            chk($sformatf("%s_rdrdy_c%0d", nm, k), 32'(rr[k]), 32'(k == 0 || k == 6));
            if (k >= 2 && k <= 5) chk($sformatf("%s_data_c%0d", nm, k), rdat[k], exp[k-2]);
        end
        chk({nm, "_data_hold"}, rdat[6], exp[3]);
    endtask

    typedef struct {
        logic [2:0]  wtype;
        logic [31:0] waddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [2:0]  rtype;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b000, 32'h0000_0040, 4'b0100, 32'h00AB_0000, 3'b010, 32'h0000_0040, 32'hFFAB_FFFF};
        vecs[1] = '{3'b001, 32'h0000_0046, 4'b1100, 32'h1234_0000, 3'b010, 32'h0000_0044, 32'h1234_FFFF};
        vecs[2] = '{3'b010, 32'h0000_0048, 4'b1111, 32'hDEAD_BEEF, 3'b011, 32'h0000_0048, 32'hDEAD_BEEF};
        vecs[3] = '{3'b010, 32'h0000_004C, 4'b0000, 32'h1234_5678, 3'b010, 32'h0000_004C, 32'hFFFF_FFFF};
        vecs[4] = '{3'b101, 32'h0000_0050, 4'b1000, 32'h7700_0000, 3'b110, 32'h0000_0050, 32'h77FF_FFFF};
        vecs[5] = '{3'b111, 32'h0001_0054, 4'b1001, 32'hAA00_00BB, 3'b000, 32'h0000_0054, 32'hAAFF_FFBB};

        reset = 1'b1; clr = 1'b1; bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        rd_req = 1'b0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk_g);
        #1;
        reset = 1'b0; clr = 1'b0;

        @(negedge clk_g);
        chk("rst_ret_valid", 32'(ret_valid), 32'd0);
        chk("rst_ret_last", 32'(ret_last), 32'd0);
        chk("rst_ret_data", ret_data, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rd_rdy", 32'(rd_rdy), 32'd1);
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
        @(posedge clk_g); #1;

        for (int i = 0; i < 4; i++) preload(32'h100 + i, 32'hA0 + 32'(i));
`ifdef CRITICAL_WORD_FIRST_EN
        line_read_capture("line_40c", 32'h0000_040C, {32'hA2, 32'hA1, 32'hA0, 32'hA3});
        line_read_capture("cwf_408", 32'h0000_0408, {32'hA1, 32'hA0, 32'hA3, 32'hA2});
`else
        line_read_capture("line_40c", 32'h0000_040C, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        line_read_capture("cwf_408", 32'h0000_0408, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
`endif

        // Reset two beats into a line read.
        wait_idle();
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_0400;
        @(negedge clk_g);
        model_read(3'b100, 32'h0000_0400);
        @(posedge clk_g); #1;
        rd_req = 1'b0;
        repeat (3) @(negedge clk_g);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk_g);
        chk("rstmid_valid_in_reset", 32'(ret_valid), 32'd0);
        chk("rstmid_mem_en_in_reset", 32'(mem_en), 32'd0);
        #1;
        reset = 1'b0;
        @(negedge clk_g);
        chk("rstmid_rd_rdy_after", 32'(rd_rdy), 32'd1);
        chk("rstmid_wr_rdy_after", 32'(wr_rdy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rstmid_no_beat_%0d", k), 32'(ret_valid), 32'd0);
            @(negedge clk_g);
        end
        @(posedge clk_g); #1;

        // Line write with per-cycle SRAM port checks, then read back.
        wait_idle();
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_0800; wr_wstrb = 4'h0;
        wr_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        @(negedge clk_g);
        chk("lw_wr_rdy_accept", 32'(wr_rdy), 32'd1);
        chk("lw_mem_en_accept", 32'(mem_en), 32'd0);
        model_write(3'b100, 32'h0000_0800, 4'h0, wr_data);
        @(posedge clk_g); #1;
        wr_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_g);
            if (k <= 4) begin
                chk($sformatf("lw_mem_en_c%0d", k), 32'(mem_en), 32'd1);
                chk($sformatf("lw_mem_we_c%0d", k), 32'(mem_we), 32'hF);
                chk($sformatf("lw_mem_addr_c%0d", k), 32'(mem_addr), 32'h200 + 32'(k - 1));
                chk($sformatf("lw_mem_wdata_c%0d", k), mem_wdata, {4{8'(8'h11 * k)}});
                chk($sformatf("lw_wr_rdy_c%0d", k), 32'(wr_rdy), 32'd0);
            end else begin
                chk("lw_wr_rdy_done", 32'(wr_rdy), 32'd1);
                chk("lw_mem_en_done", 32'(mem_en), 32'd0);
            end
        end
        @(posedge clk_g); #1;
        line_read_capture("lw_readback", 32'h0000_0800,
                          {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});

        // Simultaneous requests: write wins, read follows and sees the new data.
        wait_idle();
        wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h0000_0900; wr_wstrb = 4'hF;
        wr_data = {96'd0, 32'hCAFE_F00D};
        rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_0900;
        @(negedge clk_g);
        chk("both_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("both_rd_rdy", 32'(rd_rdy), 32'd0);
        model_write(3'b010, 32'h0000_0900, 4'hF, wr_data);
        @(posedge clk_g); #1;
        wr_req = 1'b0;
        do_req(1'b0, 3'b010, 32'h0000_0900, 4'h0, '0, 1'b1, 32'hCAFE_F00D);

        for (int i = 0; i < 6; i++) begin
            do_req(1'b1, 3'b010, vecs[i].raddr, 4'hF, 128'hFFFF_FFFF, 1'b0, '0);
            do_req(1'b1, vecs[i].wtype, vecs[i].waddr, vecs[i].strb, {96'd0, vecs[i].wdata}, 1'b0, '0);
            do_req(1'b0, vecs[i].rtype, vecs[i].raddr, 4'h0, '0, 1'b1, vecs[i].exp);
        end

        for (int i = 0; i < 300; i++) begin
            logic        w;
            logic [2:0]  t;
            logic [31:0] a;
            w = 1'($urandom_range(0, 1));
            t = 3'($urandom_range(0, 7));
            a = $urandom & 32'h0003_00FF;
            do_req(w, t, a, 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
            repeat ($urandom_range(0, 2)) @(posedge clk_g);
            #1;
        end

        wait_idle();
        chk("beats_outstanding", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
